// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains a byte FIFO read port and serialises each entry as an
//            asynchronous UART frame: start bit, DATA_WIDTH data bits LSB
//            first, optional even-parity bit, one stop bit.
// Options  : define FIFO_UART_TX_PARITY_EN to compile in the parity bit.
// Ports    : clk              - system clock, rising edge
//            rst              - synchronous reset, active low
//            fifo_data_in     - FIFO data_out, valid the cycle after a strobe
//            fifo_empty_in    - FIFO empty_out
//            fifo_read_en_out - FIFO read_en_in, 1-cycle pulse per entry
//            tx_en_in         - transmit permit, sampled only while idle
//            tx_out           - serial line, idle high
//            busy_out         - high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  input  logic                  tx_en_in,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int c_BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ZERO = '0;
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_ZERO  = '0;
  localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_LOAD   = 3'd2;
  localparam logic [2:0] c_START  = 3'd3;
  localparam logic [2:0] c_DATA   = 3'd4;
  localparam logic [2:0] c_PARITY = 3'd5;
  localparam logic [2:0] c_STOP   = 3'd6;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [c_BIT_W-1:0]    r_bit;
  logic                  r_tx;
  logic                  r_rd;
  logic                  r_busy;

  logic [2:0]            w_state_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [c_BAUD_W-1:0]   w_baud_next;
  logic [c_BIT_W-1:0]    w_bit_next;
  logic                  w_tx_next;
  logic                  w_rd_next;
  logic                  w_busy_next;
  logic                  w_baud_end;

`ifdef FIFO_UART_TX_PARITY_EN
  logic r_parity;
  logic w_parity_next;
`endif

  assign w_baud_end = (r_baud == c_BAUD_LAST);

  // State and datapath registers. The line outputs are registered from the
  // next-state values so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
      r_rd    <= w_rd_next;
      r_busy  <= w_busy_next;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      c_IDLE: begin
        if (tx_en_in && !fifo_empty_in) begin
          w_state_next = c_FETCH;
        end
      end
      c_FETCH: begin
        w_state_next = c_LOAD;
      end
      c_LOAD: begin
        // FIFO data is valid now, one cycle after the read strobe.
        w_shift_next = fifo_data_in;
        w_baud_next  = c_BAUD_ZERO;
        w_bit_next   = c_BIT_ZERO;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next = ^fifo_data_in;
`endif
        w_state_next = c_START;
      end
      c_START: begin
        if (w_baud_end) begin
          w_baud_next  = c_BAUD_ZERO;
          w_state_next = c_DATA;
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
      c_DATA: begin
        if (w_baud_end) begin
          w_baud_next  = c_BAUD_ZERO;
          w_shift_next = r_shift >> 1;
          if (r_bit == c_BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_next = c_PARITY;
`else
            w_state_next = c_STOP;
`endif
          end else begin
            w_bit_next = r_bit + c_BIT_ONE;
          end
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      c_PARITY: begin
        if (w_baud_end) begin
          w_baud_next  = c_BAUD_ZERO;
          w_state_next = c_STOP;
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
`endif
      c_STOP: begin
        if (w_baud_end) begin
          w_baud_next  = c_BAUD_ZERO;
          w_state_next = c_IDLE;
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
      default: begin
        w_state_next = c_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; the data bit comes from the
  // upcoming shift register so the first data bit appears without a shift.
  always_comb begin
    w_tx_next   = 1'b1;
    w_rd_next   = (w_state_next == c_FETCH);
    w_busy_next = (w_state_next != c_IDLE);
    case (w_state_next)
      c_START: w_tx_next = 1'b0;
      c_DATA:  w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      c_PARITY: w_tx_next = w_parity_next;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx_out           = r_tx;
  assign fifo_read_en_out = r_rd;
  assign busy_out         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx with a behavioural FIFO,
//            a UART receiver monitor and an expected-byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int c_W = 8;
  localparam int c_C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int c_BITS = c_W + 3;
`else
  localparam int c_BITS = c_W + 2;
`endif
  localparam int c_PERIOD = c_BITS * c_C + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic       tx_en = 1'b0;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (c_W),
    .CLKS_PER_BIT(c_C)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data_in    (fifo_data),
    .fifo_empty_in   (fifo_empty),
    .fifo_read_en_out(fifo_rd),
    .tx_en_in        (tx_en),
    .tx_out          (tx),
    .busy_out        (busy)
  );

  // Behavioural FIFO: registered read data and flags.
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  int         underflow = 0;

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      else underflow <= underflow + 1;
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_cnt   <= fifo_q.size();
    fifo_empty <= (fifo_q.size() == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int strobe_t[$];
  always @(negedge clk) if (fifo_rd === 1'b1) strobe_t.push_back(cyc);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic wr(input logic [7:0] b, input bit rx_exp);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (rx_exp) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // UART receiver: samples each bit mid-period.
  bit mon_en  = 1'b1;
  bit rx_busy = 1'b0;
  int rx_cnt  = 0;

  initial begin : mon
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    logic       s0;
    logic       sp;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        rx_busy = 1'b1;
        repeat (c_C / 2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < c_W; i++) begin
          repeat (c_C) @(negedge clk);
          d[i] = tx;
        end
`ifdef FIFO_UART_TX_PARITY_EN
        repeat (c_C) @(negedge clk);
        p = tx;
`endif
        repeat (c_C) @(negedge clk);
        sp = tx;
        check("rx_start", {31'd0, s0}, 32'd0);
        check("rx_stop", {31'd0, sp}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, d}, {24'd0, e});
`ifdef FIFO_UART_TX_PARITY_EN
          check("rx_parity", {31'd0, p}, {31'd0, ^e});
`endif
        end else begin
          check("rx_extra", exp_q.size(), 32'd1);
        end
        rx_cnt++;
        rx_busy = 1'b0;
      end
    end
  end

  task automatic wait_rx(input int target, input string tag);
    int n = 0;
    while ((rx_cnt < target || busy !== 1'b0 || rx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rx_timeout"}, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_strobes(input int target, input string tag);
    int n = 0;
    while (strobe_t.size() < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_strobe_timeout"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic find_strobe_now(input string tag);
    int n = 0;
    while (fifo_rd !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_strobe_seen"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] b;
    logic       e_tx;
    int         idx;
    int         base;

    // Reset held with a byte already queued.
    rst   = 1'b0;
    tx_en = 1'b1;
    wr(8'h11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_rd", {31'd0, fifo_rd}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b1;
    wait_rx(1, "t_rst");

    // Single byte, cycle-exact line check from the strobe cycle T.
    b = 8'hA5;
    wr(b, 1'b1);
    find_strobe_now("a5");
    for (int k = 1; k <= 2 + c_BITS * c_C; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("a5_rd_pulse", {31'd0, fifo_rd}, 32'd0);
        check("a5_load_tx", {31'd0, tx}, 32'd1);
      end else if (k <= 1 + c_BITS * c_C) begin
        idx = (k - 2) / c_C;
        if (idx == 0) e_tx = 1'b0;
        else if (idx <= c_W) e_tx = b[idx-1];
        else if (c_BITS == c_W + 3 && idx == c_W + 1) e_tx = ^b;
        else e_tx = 1'b1;
        check("a5_tx", {31'd0, tx}, {31'd0, e_tx});
        check("a5_busy", {31'd0, busy}, 32'd1);
      end else begin
        check("a5_busy_fall", {31'd0, busy}, 32'd0);
      end
    end
    wait_rx(2, "t_a5");

    // Back-to-back frames.
    base = strobe_t.size();
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wait_strobes(base + 2, "b2b");
    @(negedge clk);
    if (strobe_t.size() >= base + 2)
      check("b2b_period", strobe_t[base+1] - strobe_t[base], c_PERIOD);
    check("b2b_fifo_empty", fifo_cnt, 32'd0);
    wait_rx(4, "t_b2b");

    // Flow control.
    tx_en = 1'b0;
    base  = strobe_t.size();
    wr(8'h55, 1'b1);
    repeat (100) @(negedge clk);
    check("fc_hold", strobe_t.size() - base, 32'd0);
    tx_en = 1'b1;
    wait_strobes(base + 1, "fc");
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    wr(8'h66, 1'b1);
    wait_rx(5, "t_fc");
    repeat (100) @(negedge clk);
    check("fc_no_more", strobe_t.size() - base, 32'd1);
    check("fc_fifo_kept", fifo_cnt, 32'd1);
    tx_en = 1'b1;
    wait_rx(6, "t_fc2");

    // Reset during data bit 3.
    mon_en = 1'b0;
    base   = strobe_t.size();
    wr(8'h3C, 1'b0);
    find_strobe_now("mr");
    repeat (19) @(negedge clk);
    check("mr_busy_before", {31'd0, busy}, 32'd1);
    check("mr_bit3", {31'd0, tx}, 32'd1);
    rst   = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    check("mr_tx", {31'd0, tx}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_fifo_cnt", fifo_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("mr_no_reread", strobe_t.size() - base, 32'd1);
    check("mr_line_idle", {31'd0, tx}, 32'd1);
    mon_en = 1'b1;

    // Parity-sensitive bytes.
    tx_en = 1'b1;
    base  = strobe_t.size();
    wr(8'h07, 1'b1);
    wr(8'h03, 1'b1);
    wait_strobes(base + 2, "par");
    if (strobe_t.size() >= base + 2)
      check("par_period", strobe_t[base+1] - strobe_t[base], c_PERIOD);
    wait_rx(8, "t_par");

    check("underflow", underflow, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("rx_count", rx_cnt, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the byte FIFO's read port and shifts each entry out as an asynchronous UART frame: 1 start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit. It connects directly to the FIFO's `data_out` / `empty_out` / `read_en_in` signals. It owns the 1-cycle read latency of that port and produces the board-level TX line.

## Interface
- `DATA_WIDTH`, default 8: bits per frame; must match the FIFO data width.
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range is 2 or more.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `fifo_data_in`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after a read strobe.
- `fifo_empty_in`  in  1  FIFO `empty_out`.
- `fifo_read_en_out`  out  1  FIFO `read_en_in`; exactly a 1-cycle pulse per popped entry.
- `tx_en_in`  in  1  transmit permit (flow control); sampled only in IDLE.
- `tx_out`  out  1  serial line; idle-high.
- `busy_out`  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE**
  - `tx_out` = 1.
  - If `tx_en_in` is 1 and `fifo_empty_in` is 0, go to FETCH. Otherwise stay.
- **FETCH** (1 cycle)
  - `fifo_read_en_out` = 1. This is the only state that asserts it.
  - Go to LOAD.
- **LOAD** (1 cycle)
  - Latch `fifo_data_in` into the shift register and compute parity.
  - Clear the bit counter and the baud counter. Go to START.
- **START** (CLKS_PER_BIT cycles): `tx_out` = 0.
- **DATA** (DATA_WIDTH × CLKS_PER_BIT cycles)
  - `tx_out` = shift register bit 0.
  - Shift right at the end of each bit period.
  - Bit index counts 0..DATA_WIDTH-1.
- **PARITY** (CLKS_PER_BIT cycles, only when configured): `tx_out` = even-parity bit.
- **STOP** (CLKS_PER_BIT cycles): `tx_out` = 1, then go to IDLE.
- Counters
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - The bit index has $clog2(DATA_WIDTH)+1 bits; no other wrap is permitted.
- `tx_en_in` falling mid-frame does not abort the frame; the current frame always completes.
- `fifo_empty_in` is ignored outside IDLE. A FIFO write during a frame is picked up at the next IDLE.
- `fifo_read_en_out` is never asserted while `fifo_empty_in` = 1 was sampled in IDLE, so no underflow strobe is ever issued.

## Timing
- Reset values
  - State = IDLE, `tx_out` = 1, `fifo_read_en_out` = 0, `busy_out` = 0.
  - Shift register and all counters = 0.
- `tx_out`, `fifo_read_en_out` and `busy_out` are registered; they change only on the rising edge.
- Let cycle T be the cycle with `fifo_read_en_out` = 1.
  - LOAD occurs at T+1.
  - The start bit is low on cycles T+2 .. T+1+CLKS_PER_BIT.
  - Data bit i occupies cycles T+2+(i+1)·CLKS_PER_BIT .. T+1+(i+2)·CLKS_PER_BIT.
  - The stop bit ends at cycle T+1+(DATA_WIDTH+2)·CLKS_PER_BIT.
- Back-to-back frames: the next FETCH is no earlier than 2 cycles after the stop bit ends (1 IDLE cycle). Strobe-to-strobe period is (DATA_WIDTH+2)·CLKS_PER_BIT+3 cycles, or +1 bit period with parity.
- `busy_out` rises at T and falls on the first IDLE cycle.
- Reset asserted mid-frame
  - On the next edge, `tx_out` = 1 and the state is IDLE.
  - The popped byte is discarded; no re-read occurs.
- Reset in the FETCH cycle: the FIFO pops the entry anyway (FIFO reset is separate), and the byte is lost.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined
  - The PARITY state is compiled in.
  - Even parity: the bit is the XOR of all data bits.
  - Frame is DATA_WIDTH+3 bit periods.
- Undefined: no PARITY state and no parity register. DATA goes directly to STOP, and the frame is DATA_WIDTH+2 bit periods.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with FIFO non-empty → `tx_out` = 1, `fifo_read_en_out` = 0, `busy_out` = 0 throughout.
- Single byte: CLKS_PER_BIT = 4, FIFO holds 0xA5, `tx_en_in` = 1.
  - One read strobe.
  - Line shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - `busy_out` drops the following cycle.
- Back-to-back: FIFO holds 0x00 and 0xFF with CLKS_PER_BIT = 4 → strobes are exactly 43 cycles apart, and the FIFO is empty after the second strobe.
- Flow control: `tx_en_in` = 0 with 0x55 queued → no strobe for 100 cycles. Raise it, then drop it 5 cycles into the frame → the full 0x55 frame completes and no further strobe occurs.
- Reset mid-frame: assert `rst` during data bit 3 of 0x3C → `tx_out` = 1 on the next edge, FIFO count is reduced by 1, and no strobe follows with `tx_en_in` = 0.
- Parity (macro defined): send 0x07 → a parity bit of 1 precedes the stop bit; 0x03 gives parity 0. Strobe period is 47 cycles at CLKS_PER_BIT = 4.
